sum_accum: RTL

Frame accumulator sitting directly downstream of the registered 4-bit adder stage. It consumes the adder's 5-bit sum, qualified by a valid/ready handshake, and accumulates N consecutive samples into one frame result. It tracks the frame's running total, maximum and minimum, and presents the result on a valid/ready output port held until accepted.

---
 rtl/sum_accum.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sum_accum.sv
`default_nettype none
// ============================================================================
// Module   : sum_accum
// Purpose  : Frame accumulator. Sums N adder samples per frame and tracks the
//            frame max/min. The result is held on a valid/ready port until it
//            is accepted. Define SUM_ACCUM_SAT_EN to saturate the total.
// Revision : 1.0 - initial release
// ============================================================================
module sum_accum #(
    parameter int DW    = 5,
    parameter int ACC_W = 8,
    parameter int N     = 8
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [DW-1:0]    out_max,
    output logic [DW-1:0]    out_min,
    output logic             out_ovf
);

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [DW-1:0]    max_q;
    logic [DW-1:0]    min_q;
    logic [CW-1:0]    cnt;
    logic             ovf;

    logic             accept;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_nxt;
    logic [DW-1:0]    max_nxt;
    logic [DW-1:0]    min_nxt;

    // Handshake flags are pure decodes of the state register, so no bypass.
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(in_sum);
    assign carry   = sum_ext[ACC_W];
`ifdef SUM_ACCUM_SAT_EN
    assign acc_nxt = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_nxt = sum_ext[ACC_W-1:0];
`endif
    assign max_nxt = (in_sum > max_q) ? in_sum : max_q;
    assign min_nxt = (in_sum < min_q) ? in_sum : min_q;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            max_q     <= '0;
            min_q     <= '1;
            out_total <= '0;
            out_max   <= '0;
            out_min   <= '1;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            // Result data registers deliberately keep their last frame.
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= ACC_W'(in_sum);
                        max_q <= in_sum;
                        min_q <= in_sum;
                        cnt   <= CW'(1);
                        ovf   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc   <= acc_nxt;
                        max_q <= max_nxt;
                        min_q <= min_nxt;
                        ovf   <= ovf | carry;
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            out_total <= acc_nxt;
                            out_max   <= max_nxt;
                            out_min   <= min_nxt;
                            out_ovf   <= ovf | carry;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
